bit2real_ramp: RTL
==================

# bit2real_ramp

Clocked logic-to-real converter: samples a 1-bit logic input on each clock and drives a real-valued output that ramps linearly between `vlo` and `vhi` over a fixed number of clock cycles. It is the driving end of the threshold-detector interface: logic-domain blocks use it to stimulate analog-behavioural (real-valued) nets with finite, deterministic transition edges. A state machine tracks the settled and transitioning conditions, and reversal mid-ramp is supported.

## Interface
- `vlo`, 0.0, real output value for logic 0 (settled low)
- `vhi`, 1.0, real output value for logic 1 (settled high); `vhi` > `vlo` required
- `RAMP_CYCLES`, 4, integer ≥ 1; clock edges needed for a full low→high or high→low swing
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  reset, synchronous, active-high
- `en`  input  1  advance enable; when 0, all state and the output are frozen
- `in`  input  1  logic target level
- `out`  output  real  ramped real value, declared with the codebase's real-port macro
- `busy`  output  1  high while a ramp is in progress (state RISE or FALL)
- `level`  output  1  settled logic level: 1 only in HIGH, 0 only in LOW, holds previous settled value during ramps

## Operation
- Internal counter `cnt`, width `$clog2(RAMP_CYCLES+1)`, range 0..RAMP_CYCLES, never wraps.
- `out` = `vlo` + (`vhi`−`vlo`) × `cnt` / `RAMP_CYCLES`, computed in real arithmetic from the registered `cnt`. `cnt`=0 gives exactly `vlo`; `cnt`=RAMP_CYCLES gives exactly `vhi`.
- States: LOW (`cnt`=0), RISE, HIGH (`cnt`=RAMP_CYCLES), FALL.
- Each rising edge with `rst`=0 and `en`=1:
  - LOW: `in`=1 → `cnt`=1; next state is RISE, or HIGH if RAMP_CYCLES=1. `in`=0 → stay.
  - RISE: `in`=1 → `cnt`+1; next state is HIGH when the new `cnt`=RAMP_CYCLES. `in`=0 → reversal: `cnt`−1, go to FALL, or LOW if the new `cnt`=0.
  - HIGH: `in`=0 → `cnt`=RAMP_CYCLES−1; next state is FALL, or LOW if RAMP_CYCLES=1. `in`=1 → stay.
  - FALL: mirror image of RISE.
- `en`=0: state, `cnt`, `out`, `busy` and `level` all hold. The `in` value during this period is ignored.
- `level` is registered. It is set to 1 on entering HIGH and cleared to 0 on entering LOW.

## Timing
- Reset (`rst`=1 at a rising edge) overrides `en` and `in`. After that edge: state=LOW, `cnt`=0, `out`=`vlo`, `busy`=0, `level`=0. Reset mid-ramp snaps `out` to `vlo` on that edge with no ramp.
- Latency: an `in` change sampled at edge k moves `out` by one step after edge k. A full swing completes at edge k+RAMP_CYCLES−1 (RAMP_CYCLES enabled edges), and `busy` falls on that same edge.
- `out` changes only at clock edges, at most one step of (`vhi`−`vlo`)/RAMP_CYCLES per enabled edge.
- Reversal costs no idle cycle: the direction changes on the edge that samples the new `in`.
- `in` toggling every cycle during a ramp causes `out` to oscillate by ±1 step. It never goes beyond `vlo`..`vhi`.

## Structure
- Shared package holds the state enum typedef `b2r_state_t` {LOW, RISE, HIGH, FALL}.
- Single module, no sub-module: one `always_ff` for state/`cnt`/`level`, with combinational assignments for `out` and `busy`.
- Elaboration-time check: fatal if RAMP_CYCLES<1 or `vhi`≤`vlo`.

## Test plan
All scenarios use `vlo`=0.0, `vhi`=1.0, RAMP_CYCLES=4 unless stated.
- Reset with `in`=1, `en`=1 → `out`=0.0, `busy`=0, `level`=0. Release reset → `out` goes 0.25, 0.5, 0.75, 1.0 on successive edges, `busy` falls and `level` rises on the 4th edge.
- From HIGH, `in`=0 for 2 edges then `in`=1 → `out` goes 0.75, 0.5, then 0.75, 1.0. State goes FALL→RISE→HIGH and `level` stays 1 throughout.
- Mid-rise at `out`=0.5, `en`=0 for 5 cycles with `in` toggling → `out` holds 0.5. Re-enable with `in`=1 → 0.75, then 1.0.
- Mid-fall at `out`=0.5, assert `rst` for one edge → `out`=0.0, state LOW, `busy`=0 immediately after that edge.
- RAMP_CYCLES=1, `vlo`=0.2, `vhi`=1.2, `in` alternating every cycle → `out` alternates 1.2/0.2 each edge, `busy` is always 0, `level` follows `in` delayed by one edge.
- `in` toggling every edge starting from LOW → `out` alternates 0.25/0.0 and never leaves 0.0..1.0.

Source files
------------

// File: rtl/bit2real_ramp_pkg.sv
// Shared types for the logic-to-real ramp driver: FSM state encoding and the
// port type used for real-valued (analog-behavioural) nets.
`ifndef B2R_REAL_PORT
`define B2R_REAL_PORT real
`endif

package bit2real_ramp_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } b2r_state_t;

endpackage

// File: rtl/bit2real_ramp_if.sv
// Logic-side controls and real-valued outputs of the ramp driver.
interface bit2real_ramp_if;

    logic             en;
    logic             in;
    `B2R_REAL_PORT    out;
    logic             busy;
    logic             level;

    modport master (output en, in, input out, busy, level);
    modport slave  (input en, in, output out, busy, level);

endinterface

// File: rtl/bit2real_ramp.sv
// Converts a sampled logic level into a real output that ramps linearly between
// vlo and vhi over RAMP_CYCLES enabled clock edges, with reversal mid-ramp.
//
//  state | meaning
//  ------+-------------------------------------------
//  LOW   | settled at vlo, cnt = 0
//  RISE  | ramping toward vhi, 0 < cnt < RAMP_CYCLES
//  HIGH  | settled at vhi, cnt = RAMP_CYCLES
//  FALL  | ramping toward vlo, 0 < cnt < RAMP_CYCLES
module bit2real_ramp
    import bit2real_ramp_pkg::*;
#(
    parameter real vlo         = 0.0,
    parameter real vhi         = 1.0,
    parameter int  RAMP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    bit2real_ramp_if.slave    bus_io
);

    localparam int CW = (RAMP_CYCLES < 1) ? 1 : $clog2(RAMP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RAMP_CYCLES);

    if (RAMP_CYCLES < 1 || vhi <= vlo) begin : g_bad_cfg
        $fatal(1, "bit2real_ramp: needs RAMP_CYCLES >= 1 and vhi > vlo");
    end

    b2r_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           level_q, level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (bus_io.en) begin
            unique case (state_q)
                LOW: begin
                    if (bus_io.in) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_MAX) ? HIGH : RISE;
                    end
                end
                HIGH: begin
                    if (!bus_io.in) begin
                        cnt_d   = CNT_MAX - CNT_ONE;
                        state_d = (cnt_d == CNT_ZERO) ? LOW : FALL;
                    end
                end
                // Mid-ramp the direction simply follows in, so reversal costs no cycle.
                RISE, FALL: begin
                    if (bus_io.in) begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = (cnt_d == CNT_MAX) ? HIGH : RISE;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = (cnt_d == CNT_ZERO) ? LOW : FALL;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = CNT_ZERO;
                end
            endcase
            if (state_d == HIGH) begin
                level_d = 1'b1;
            end else if (state_d == LOW) begin
                level_d = 1'b0;
            end
        end
    end

    // End points are forced so the settled values are exact regardless of rounding.
    always_comb begin
        if (cnt_q == CNT_ZERO) begin
            bus_io.out = vlo;
        end else if (cnt_q == CNT_MAX) begin
            bus_io.out = vhi;
        end else begin
            bus_io.out = vlo + (vhi - vlo) * real'(cnt_q) / real'(RAMP_CYCLES);
        end
    end

    assign bus_io.busy  = (state_q == RISE) || (state_q == FALL);
    assign bus_io.level = level_q;

endmodule
